// File: rtl/mem_copy_engine.sv
// -----------------------------------------------------------------------------
// mem_copy_engine
//
// Block-transfer engine that drives the single-port main memory on behalf of
// the control unit. Two operations are supported:
//   copy (mode = 0): for each word, read src_base + i, then write it to
//                    dst_base + i, in ascending order.
//   fill (mode = 1): write fill_pattern to dst_base + i for each word.
// Address arithmetic wraps modulo 2**address_length.
//
// Ports
//   clk               system clock, rising edge
//   reset             asynchronous, active-high reset; aborts any transfer
//   start             request pulse, only honoured in IDLE
//   mode              0 = copy, 1 = fill (sampled with start)
//   src_addr          copy source base (ignored for fill)
//   dst_addr          destination base
//   length            word count, 0 .. 2**address_length
//   fill_pattern      fill value (sampled with start)
//   busy              high while reading/writing memory
//   done              one-cycle completion pulse
//   words_done        words written in the current or last transfer
//   mem_address       memory address
//   mem_write_data    memory write data
//   mem_write_enable  memory write strobe, only ever high in WRITE
//   mem_read_data     memory read data, combinational on mem_address
// -----------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int address_length = 3,
  parameter int data_width     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      mode,
  input  logic [address_length-1:0] src_addr,
  input  logic [address_length-1:0] dst_addr,
  input  logic [address_length:0]   length,
  input  logic [data_width-1:0]     fill_pattern,
  output logic                      busy,
  output logic                      done,
  output logic [address_length:0]   words_done,
  output logic [address_length-1:0] mem_address,
  output logic [data_width-1:0]     mem_write_data,
  output logic                      mem_write_enable,
  input  logic [data_width-1:0]     mem_read_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [address_length:0] ONE = {{address_length{1'b0}}, 1'b1};

  logic [1:0]                r_state;
  logic                      r_mode;
  logic [address_length-1:0] r_src_base;
  logic [address_length-1:0] r_dst_base;
  logic [address_length:0]   r_length;
  logic [data_width-1:0]     r_pattern;
  logic [data_width-1:0]     r_buffer;
  // Word index of the transfer; it is also the number of words written so far,
  // so it doubles as words_done.
  logic [address_length:0]   r_count;

  logic [address_length:0]   w_count_next;
  logic                      w_last;

  assign w_count_next = r_count + ONE;
  assign w_last       = (w_count_next == r_length);

  // NOTE: every register, including the data buffer, is reset so outputs are
  // deterministic straight out of reset; non-blocking assignments keep all
  // state updates in this block reading pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_src_base <= '0;
      r_dst_base <= '0;
      r_length   <= '0;
      r_pattern  <= '0;
      r_buffer   <= '0;
      r_count    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_src_base <= src_addr;
            r_dst_base <= dst_addr;
            r_length   <= length;
            r_pattern  <= fill_pattern;
            r_count    <= '0;
            if (length == '0)  r_state <= S_DONE;
            else if (mode)     r_state <= S_WRITE;
            else               r_state <= S_READ;
          end
        end
        S_READ: begin
          r_buffer <= mem_read_data;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_count <= w_count_next;
          if (w_last)       r_state <= S_DONE;
          else if (r_mode)  r_state <= S_WRITE;
          else              r_state <= S_READ;
        end
        default: r_state <= S_IDLE;  // S_DONE: single-cycle pulse
      endcase
    end
  end

  // Memory-side outputs decode straight from the state register, so an
  // asynchronous reset drops mem_write_enable without waiting for a clock.
  // NOTE: every output gets a default first so no path through the case can
  // infer a latch.
  always_comb begin
    busy             = 1'b0;
    done             = 1'b0;
    mem_address      = '0;
    mem_write_data   = '0;
    mem_write_enable = 1'b0;
    case (r_state)
      S_READ: begin
        busy        = 1'b1;
        mem_address = r_src_base + r_count[address_length-1:0];
      end
      S_WRITE: begin
        busy             = 1'b1;
        mem_address      = r_dst_base + r_count[address_length-1:0];
        mem_write_enable = 1'b1;
        mem_write_data   = r_mode ? r_pattern : r_buffer;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign words_done = r_count;

endmodule

// File: tb/tb_mem_copy_engine.sv
// -----------------------------------------------------------------------------
// tb_mem_copy_engine
//
// Scoreboard bench: each transfer pushes its expected memory writes and its
// expected done event into queues; a monitor on the falling edge pops and
// compares whenever the engine writes memory or pulses done. Final memory
// contents are compared against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_copy_engine;

  localparam int AL    = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AL;

  typedef struct {
    logic [AL-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int cycle;
    int words;
    int busy_cycles;
  } done_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          mode;
  logic [AL-1:0] src_addr;
  logic [AL-1:0] dst_addr;
  logic [AL:0]   length;
  logic [DW-1:0] fill_pattern;
  logic          busy;
  logic          done;
  logic [AL:0]   words_done;
  logic [AL-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;

  // Main memory model with a bench-side preload path.
  logic [DW-1:0] mem         [DEPTH];
  logic [DW-1:0] preload_img [DEPTH];
  logic [DW-1:0] model_mem   [DEPTH];
  logic          preload_req = 1'b0;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_run = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preload_req) mem <= preload_img;
    else if (mem_write_enable) mem[mem_address] <= mem_write_data;
  end
  assign mem_read_data = mem[mem_address];

  mem_copy_engine #(.address_length(AL), .data_width(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .mode             (mode),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
    .fill_pattern     (fill_pattern),
    .busy             (busy),
    .done             (done),
    .words_done       (words_done),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT writes memory or pulses done.
  always @(negedge clk) begin
    wr_t   w;
    done_t d;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (mem_write_enable) begin
        check("we_only_when_busy", 64'(busy), 64'd1);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(mem_address), 64'hFFFF);
        end else begin
          w = exp_wr.pop_front();
          check("wr_addr", 64'(mem_address), 64'(w.addr));
          check("wr_data", 64'(mem_write_data), 64'(w.data));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 64'(cyc), 64'hFFFF);
        end else begin
          d = exp_done.pop_front();
          check("done_cycle", 64'(cyc), 64'(d.cycle));
          check("done_words", 64'(words_done), 64'(d.words));
          check("busy_cycles", 64'(busy_run), 64'(d.busy_cycles));
          check("busy_low_at_done", 64'(busy), 64'd0);
        end
        busy_run = 0;
      end
    end
  end

  task automatic preload(input int base);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      preload_img[i] = DW'(base + i);
      model_mem[i]   = DW'(base + i);
    end
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
  endtask

  // Drives one start pulse; returns at the falling edge after the sampling edge.
  task automatic start_xfer(input logic m, input logic [AL-1:0] s, input logic [AL-1:0] d,
                            input logic [AL:0] n, input logic [DW-1:0] p, input bit use_model);
    logic [AL-1:0] sa;
    logic [AL-1:0] da;
    logic [DW-1:0] v;
    done_t         de;
    @(negedge clk);
    if (use_model) begin
      for (int i = 0; i < int'(n); i++) begin
        sa = s + AL'(i);
        da = d + AL'(i);
        v  = m ? p : model_mem[sa];
        model_mem[da] = v;
        exp_wr.push_back('{addr: da, data: v});
      end
      de.cycle       = cyc + 1 + (m ? int'(n) : 2 * int'(n));
      de.words       = int'(n);
      de.busy_cycles = m ? int'(n) : 2 * int'(n);
      exp_done.push_back(de);
    end
    mode = m; src_addr = s; dst_addr = d; length = n; fill_pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_pattern = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_done",       64'(done), 64'd0);
    check("rst_words_done", 64'(words_done), 64'd0);
    check("rst_addr",       64'(mem_address), 64'd0);
    check("rst_wdata",      64'(mem_write_data), 64'd0);
    check("rst_we",         64'(mem_write_enable), 64'd0);
    reset = 1'b0;

    // Copy 0..2 -> 4..6
    preload(10);
    start_xfer(1'b0, 3'd0, 3'd4, 4'd3, 32'h0, 1'b1);
    wait_done(20);
    check("copy_mem3", 64'(mem[3]), 64'd13);
    check("copy_mem4", 64'(mem[4]), 64'd10);
    check("copy_mem5", 64'(mem[5]), 64'd11);
    check("copy_mem6", 64'(mem[6]), 64'd12);
    check("copy_mem7", 64'(mem[7]), 64'd17);
    check("copy_words_done", 64'(words_done), 64'd3);

    // Fill with wrap: 6,7,0,1
    start_xfer(1'b1, 3'd0, 3'd6, 4'd4, 32'hDEADBEEF, 1'b1);
    wait_done(20);
    check("fill_mem6", 64'(mem[6]), 64'hDEADBEEF);
    check("fill_mem7", 64'(mem[7]), 64'hDEADBEEF);
    check("fill_mem0", 64'(mem[0]), 64'hDEADBEEF);
    check("fill_mem1", 64'(mem[1]), 64'hDEADBEEF);
    check("fill_mem5", 64'(mem[5]), 64'd11);
    check("fill_mem2", 64'(mem[2]), 64'd12);
    check("fill_words_done_hold", 64'(words_done), 64'd4);

    // Zero length
    start_xfer(1'b0, 3'd1, 3'd2, 4'd0, 32'h0, 1'b1);
    wait_done(5);
    check("zero_words_done", 64'(words_done), 64'd0);
    check("zero_mem2", 64'(mem[2]), 64'd12);

    // Overlapping copy with an ignored start while busy
    preload(0);
    start_xfer(1'b0, 3'd0, 3'd1, 4'd3, 32'h0, 1'b1);
    @(negedge clk);
    mode = 1'b1; dst_addr = 3'd5; length = 4'd2; fill_pattern = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    repeat (3) @(negedge clk);
    check("ovl_mem0", 64'(mem[0]), 64'd0);
    check("ovl_mem1", 64'(mem[1]), 64'd0);
    check("ovl_mem2", 64'(mem[2]), 64'd0);
    check("ovl_mem3", 64'(mem[3]), 64'd0);
    check("ovl_mem4", 64'(mem[4]), 64'd4);
    check("ovl_mem5_untouched", 64'(mem[5]), 64'd5);
    check("ovl_words_done", 64'(words_done), 64'd3);

    // Full span fill, wrapping from base 3
    start_xfer(1'b1, 3'd0, 3'd3, 4'd8, 32'h1, 1'b1);
    wait_done(20);
    for (int i = 0; i < DEPTH; i++) check($sformatf("full_mem%0d", i), 64'(mem[i]), 64'd1);
    check("full_words_done", 64'(words_done), 64'd8);

    // Reset mid-fill after two writes (addresses 2 and 3)
    preload(100);
    exp_wr.push_back('{addr: 3'd2, data: 32'hA5A5A5A5});
    exp_wr.push_back('{addr: 3'd3, data: 32'hA5A5A5A5});
    model_mem[2] = 32'hA5A5A5A5;
    model_mem[3] = 32'hA5A5A5A5;
    start_xfer(1'b1, 3'd0, 3'd2, 4'd6, 32'hA5A5A5A5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_we",   64'(mem_write_enable), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    check("abort_words_done", 64'(words_done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem1", 64'(mem[1]), 64'd101);
    check("abort_mem2", 64'(mem[2]), 64'hA5A5A5A5);
    check("abort_mem3", 64'(mem[3]), 64'hA5A5A5A5);
    check("abort_mem4", 64'(mem[4]), 64'd104);

    // Normal operation after the abort
    start_xfer(1'b0, 3'd2, 3'd6, 4'd2, 32'h0, 1'b1);
    wait_done(20);
    check("post_mem6", 64'(mem[6]), 64'hA5A5A5A5);
    check("post_mem7", 64'(mem[7]), 64'hA5A5A5A5);
    check("post_mem5", 64'(mem[5]), 64'd105);
    check("post_words_done", 64'(words_done), 64'd2);

    repeat (3) @(negedge clk);
    check("writes_drained", 64'(exp_wr.size()), 64'd0);
    check("done_drained",   64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
